// File: rtl/dc_input_split.sv
// dc_input_split: natural-order serial stream to (x[i], x[i+N/2]) pairs.
// Optional out_sof port is enabled by the DC_SPLIT_SOF_EN macro.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_data/valid/sof sample input, no backpressure
//   out_x0, out_x1    paired samples x[i], x[i+N/2] (registered)
//   out_valid         pair valid (registered)
//   out_sof           pair i = 0 (DC_SPLIT_SOF_EN only)
module dc_input_split #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic [DATA_WIDTH-1:0] out_x0,
  output logic [DATA_WIDTH-1:0] out_x1,
`ifdef DC_SPLIT_SOF_EN
  output logic                  out_sof,
`endif
  output logic                  out_valid
);

  localparam int CW = $clog2(N);
  localparam int H  = N / 2;

  logic [DATA_WIDTH-1:0] half_buf [H];
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         k;
  logic [CW-2:0]         addr;
  logic                  pair;

  // in_sof forces index 0, dropping any partial frame.
  assign k    = in_sof ? '0 : cnt;
  assign pair = k[CW-1];
  assign addr = k[CW-2:0];

  // Buffer carries no reset; every entry is rewritten in FILL
  // before PAIR can read it.
  always_ff @(posedge clk) begin
    if (in_valid && !pair) begin
      half_buf[addr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_x0    <= '0;
      out_x1    <= '0;
    end else if (in_valid) begin
      // N is a power of two, so k+1 wraps N-1 -> 0.
      cnt       <= k + CW'(1);
      out_valid <= pair;
      if (pair) begin
        out_x0 <= half_buf[addr];
        out_x1 <= in_data;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef DC_SPLIT_SOF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out_sof <= 1'b0;
    end else begin
      out_sof <= in_valid && pair && (addr == '0);
    end
  end
`endif

endmodule

// File: tb/tb_dc_input_split.sv
// tb_dc_input_split: directed and random stimulus against a
// frame-queue reference model of the input commutator.
module tb_dc_input_split;

  parameter int N  = 16;
  localparam int DW = 32;
  localparam int H  = N / 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] out_x0;
  logic [DW-1:0] out_x1;
  logic          out_valid;
`ifdef DC_SPLIT_SOF_EN
  logic          out_sof;
`endif

  always #5 clk = ~clk;

  dc_input_split #(
    .DATA_WIDTH(DW),
    .N(N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_sof(in_sof),
    .out_x0(out_x0),
    .out_x1(out_x1),
`ifdef DC_SPLIT_SOF_EN
    .out_sof(out_sof),
`endif
    .out_valid(out_valid)
  );

  int errors;
  int checks;

  // Model: the samples of the current frame, in arrival order.
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_x0;
  logic [DW-1:0] m_x1;
  logic          m_v;
  logic          m_sof;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v,
                      input logic s, input logic [DW-1:0] d);
    reset    = r;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    m_v   = 1'b0;
    m_sof = 1'b0;
    if (r) begin
      q.delete();
      m_x0 = '0;
      m_x1 = '0;
    end else if (v) begin
      if (s) q.delete();
      q.push_back(d);
      if (q.size() > H) begin
        m_x0  = q[q.size() - 1 - H];
        m_x1  = d;
        m_v   = 1'b1;
        m_sof = (q.size() == H + 1);
      end
      if (q.size() == N) q.delete();
    end
    #1;
    chk("valid", 64'(out_valid), 64'(m_v));
    chk("x0", 64'(out_x0), 64'(m_x0));
    chk("x1", 64'(out_x1), 64'(m_x1));
`ifdef DC_SPLIT_SOF_EN
    chk("sof", 64'(out_sof), 64'(m_sof));
`endif
  endtask

  initial begin
    int first;
    int nv;
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    m_x0     = '0;
    m_x1     = '0;
    m_v      = 1'b0;
    m_sof    = 1'b0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    first = -1;
    nv    = 0;
    for (int i = 0; i < N; i++) begin
      step(0, 1, i == 0, DW'(i));
      if (out_valid) begin
        if (first < 0) first = i;
        nv++;
      end
    end
    chk("latency", 64'(first), 64'(H));
    chk("npairs", 64'(nv), 64'(H));

    for (int i = 0; i < N; i++)
      step(0, 1, i == 0, DW'(i));
    for (int i = 0; i < N; i++)
      step(0, 1, i == 0, DW'(100 + i));
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, $urandom);

    nv = 0;
    for (int i = 0; i < N; i++) begin
      step(0, 1, i == 0, DW'(i));
      if (out_valid) nv++;
      step(0, 0, $urandom_range(0, 1) == 1, $urandom);
    end
    chk("gap_npairs", 64'(nv), 64'(H));

    for (int i = 0; i <= 10; i++)
      step(0, 1, i == 0, DW'(i));
    for (int i = 0; i < N; i++)
      step(0, 1, i == 0, DW'(50 + i));

    for (int i = 0; i <= 11; i++)
      step(0, 1, i == 0, DW'(i));
    step(1, 1, 0, 12);
    for (int i = 0; i < N; i++)
      step(0, 1, 0, DW'(200 + i));

    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic v;
      logic s;
      r = ($urandom % 200) == 0;
      v = ($urandom % 4) != 0;
      s = ($urandom % 40) == 0;
      step(r, v, s, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dc_input_split.md
# dc_input_split

Serial-to-dual-path input commutator for the radix-2 MDC FFT pipeline. It accepts one complex sample per cycle in natural order and emits the paired stream (x[i], x[i+N/2]) on two lanes for the `dc_top` delay-commutator chain. It sits directly ahead of `dc_top`: `out_x0`/`out_x1`/`out_valid` drive its `x0`/`x1` inputs and their validity. It buffers the first half of each N-point frame and pairs it with the second half as that half arrives.

## Interface
- `DATA_WIDTH`, 32: sample width in bits (packed complex word, treated as opaque).
- `N`, 16: FFT frame length; power of two, N ≥ 4.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  DATA_WIDTH  input sample.
- `in_valid`  in  1  `in_data` is valid this cycle. There is no backpressure: the block always accepts.
- `in_sof`  in  1  start of frame. Only meaningful when `in_valid` = 1.
- `out_x0`  out  DATA_WIDTH  lane 0 sample x[i], i in 0..N/2-1.
- `out_x1`  out  DATA_WIDTH  lane 1 sample x[i+N/2].
- `out_valid`  out  1  the `out_x0`/`out_x1` pair is valid.
- `out_sof`  out  1  first pair (i = 0) of a frame. Present only with `DC_SPLIT_SOF_EN`.

## Operation
- Half-frame buffer `buf`: N/2 × DATA_WIDTH. It is not reset.
- Sample counter `cnt`: $clog2(N) bits, range 0..N-1.
- Two implicit phases, selected by the counter MSB:
  - FILL: `cnt` < N/2.
  - PAIR: `cnt` ≥ N/2.
- Accepted sample means `in_valid` = 1. For each accepted sample:
  - Effective index k = 0 if `in_sof` = 1, else k = `cnt`.
  - If k < N/2 (FILL): `buf[k]` <= `in_data`. No output is produced.
  - If k ≥ N/2 (PAIR): `out_x0` <= `buf[k-N/2]`, `out_x1` <= `in_data`, `out_valid` <= 1.
  - Counter update: `cnt` <= k+1, wrapping from N-1 to 0.
- Cycles with `in_valid` = 0: `cnt` holds, `out_valid` <= 0, and `out_x0`/`out_x1` hold their last values.
- `in_sof` with `in_valid` = 0 is ignored.
- A PAIR write and the next frame's FILL write never target the same `buf` entry in the same cycle. The buffer is single-port: one write or one read per cycle.
- Mid-frame `in_sof` abandons the partial frame:
  - Unpaired buffered samples are discarded.
  - No pairs are emitted for the abandoned frame.
  - The new frame starts at index 0.
- Frames run back-to-back with no idle cycle required. Average throughput is one sample per cycle; output duty is 50 % at full input rate.

## Timing
- Reset values: `cnt` = 0, `out_valid` = 0, `out_x0` = 0, `out_x1` = 0, `out_sof` = 0.
- Latency: a pair appears on the cycle after the clock edge that accepts x[i+N/2]. With continuous input this is N/2+1 cycles after x[0] is accepted.
- All outputs are registered. No combinational path exists from inputs to outputs.
- `reset` asserted mid-frame: the next edge clears `cnt` and the outputs, and the partial frame is lost. The first sample accepted after reset is index 0 whether or not `in_sof` is set.
- `reset` has priority over `in_valid`/`in_sof` in the same cycle.

## Configuration
- `DC_SPLIT_SOF_EN` defined:
  - The `out_sof` port exists.
  - It is registered alongside `out_valid` and is high exactly when the emitted pair has i = 0 (k = N/2).
  - It is 0 whenever `out_valid` = 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- N=16, continuous `in_data` 0..15 with `in_sof` on 0 → eight consecutive `out_valid` cycles carrying (0,8),(1,9)…(7,15). The first pair appears 9 cycles after sample 0 is accepted, and `out_sof` is high only on (0,8).
- N=16, two frames back-to-back (0..15 then 100..115) → pairs (0,8)…(7,15), then 8 invalid cycles, then (100,108)…(107,115). There are no stray valids.
- N=16, `in_valid` toggling 1,0,1,0 over frame 0..15 → the same eight pairs in order, each one cycle after its lane-1 sample. Outputs hold during gaps.
- N=16, `in_sof` reasserted with sample 50 after samples 0..10 → no pairs from the old frame after (2,10). The new frame 50..65 yields (50,58)…(57,65).
- Reset asserted after sample 11 of a frame, then samples 200..215 → outputs read 0 with `out_valid` = 0 the cycle after reset. The pairs produced are (200,208)…(207,215).
- N=8 build, continuous 0..7 → pairs (0,4),(1,5),(2,6),(3,7), the first one 5 cycles after sample 0.
